// File: rtl/lock_pkg.sv
// Shared lock definitions: keypad key codes consumed downstream and the
// keypad scanner state encoding.
package lock_pkg;

   localparam logic [3:0] KC_0    = 4'h0;
   localparam logic [3:0] KC_1    = 4'h1;
   localparam logic [3:0] KC_2    = 4'h2;
   localparam logic [3:0] KC_3    = 4'h3;
   localparam logic [3:0] KC_4    = 4'h4;
   localparam logic [3:0] KC_5    = 4'h5;
   localparam logic [3:0] KC_6    = 4'h6;
   localparam logic [3:0] KC_7    = 4'h7;
   localparam logic [3:0] KC_8    = 4'h8;
   localparam logic [3:0] KC_9    = 4'h9;
   localparam logic [3:0] KC_A    = 4'hA;
   localparam logic [3:0] KC_B    = 4'hB;
   localparam logic [3:0] KC_C    = 4'hC;
   localparam logic [3:0] KC_D    = 4'hD;
   localparam logic [3:0] KC_HASH = 4'hE;
   localparam logic [3:0] KC_STAR = 4'hF;

   typedef enum logic [2:0] {
      S_SCAN,
      S_PRESS_DB,
      S_EMIT,
      S_HOLD,
      S_REL_DB
   } keypad_state_t;

   // Physical keypad layout: {row, col} -> key code.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = KC_0;
      case ({row, col})
         4'h0: code = KC_1;
         4'h1: code = KC_2;
         4'h2: code = KC_3;
         4'h3: code = KC_A;
         4'h4: code = KC_4;
         4'h5: code = KC_5;
         4'h6: code = KC_6;
         4'h7: code = KC_B;
         4'h8: code = KC_7;
         4'h9: code = KC_8;
         4'hA: code = KC_9;
         4'hB: code = KC_C;
         4'hC: code = KC_STAR;
         4'hD: code = KC_0;
         4'hE: code = KC_HASH;
         4'hF: code = KC_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones so idle
// pulled-up lines read as inactive.
module keypad_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad and emits one debounced key_valid pulse per press.
// Optional macro KEYPAD_REPEAT_EN adds auto-repeat while a key stays held.
module keypad_scanner
   import lock_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_pressed
);

   localparam int DIV_W = $clog2(SCAN_DIV) + 1;
   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   keypad_state_t    state, state_next;
   logic [3:0]       rows_s;
   logic [1:0]       col_idx, row_idx, hit_row;
   logic [DIV_W-1:0] div_cnt;
   logic [DEB_W-1:0] deb_cnt;
   logic             one_low, rows_match, all_high, scan_done, deb_done;
   logic             press_done, release_done, rep_fire;

   keypad_sync #(.WIDTH(4)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_i),
      .q   (rows_s)
   );

   // Chords (two or more rows low) are deliberately not treated as a hit.
   always_comb begin
      one_low = 1'b1;
      hit_row = 2'd0;
      case (rows_s)
         4'b1110: hit_row = 2'd0;
         4'b1101: hit_row = 2'd1;
         4'b1011: hit_row = 2'd2;
         4'b0111: hit_row = 2'd3;
         default: one_low = 1'b0;
      endcase
   end

   assign rows_match = (rows_s == ~(4'b0001 << row_idx));
   assign all_high   = (rows_s == 4'hF);
   assign scan_done  = (div_cnt >= DIV_LAST);
   assign deb_done   = (deb_cnt >= DEB_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= S_SCAN;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_SCAN:     if (scan_done && one_low) state_next = S_PRESS_DB;
         S_PRESS_DB: if (!rows_match)          state_next = S_SCAN;
                     else if (deb_done)        state_next = S_EMIT;
         S_EMIT:                               state_next = S_HOLD;
         S_HOLD:     if (all_high)             state_next = S_REL_DB;
         S_REL_DB:   if (!all_high)            state_next = S_HOLD;
                     else if (deb_done)        state_next = S_SCAN;
         default:                              state_next = S_SCAN;
      endcase
   end

   always_comb begin
      col_o        = ~(4'b0001 << col_idx);
      press_done   = (state == S_PRESS_DB) && (state_next == S_EMIT);
      release_done = (state == S_REL_DB) && (state_next == S_SCAN);
   end

   // Outputs are registered on the transition so the pulse lines up with S_EMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_idx     <= 2'd0;
         row_idx     <= 2'd0;
         div_cnt     <= '0;
         deb_cnt     <= '0;
         key_valid   <= 1'b0;
         key_code    <= KC_0;
         key_pressed <= 1'b0;
      end else begin
         key_valid <= press_done || rep_fire;
         if (press_done) begin
            key_code    <= key_map(row_idx, col_idx);
            key_pressed <= 1'b1;
         end else if (release_done) begin
            key_pressed <= 1'b0;
         end

         case (state)
            S_SCAN: begin
               if (scan_done) begin
                  div_cnt <= '0;
                  if (one_low) begin
                     row_idx <= hit_row;
                     deb_cnt <= DEB_W'(1);
                  end else begin
                     col_idx <= col_idx + 2'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            S_PRESS_DB: begin
               if (!rows_match) begin
                  div_cnt <= '0;
                  deb_cnt <= '0;
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end
            S_EMIT: deb_cnt <= '0;
            S_HOLD: if (all_high) deb_cnt <= DEB_W'(1);
            S_REL_DB: begin
               if (!all_high) begin
                  deb_cnt <= '0;
               end else if (deb_done) begin
                  deb_cnt <= '0;
                  div_cnt <= '0;
                  col_idx <= col_idx + 2'd1;
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end
            default: deb_cnt <= '0;
         endcase
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX) + 1;
   localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

   logic [REP_W-1:0] rep_cnt;
   logic             rep_first;

   assign rep_fire = (state == S_HOLD) && !all_high &&
                     (rep_cnt >= (rep_first ? DELAY_LAST : RATE_LAST));

   // rep_cnt holds cycles since the last pulse; a visit to S_REL_DB drops back to the rate interval.
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else if (state == S_EMIT) begin
         rep_cnt   <= REP_W'(1);
         rep_first <= 1'b1;
      end else if ((state == S_HOLD) && !all_high) begin
         if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
         end
      end else begin
         rep_cnt <= '0;
         if (state == S_REL_DB) rep_first <= 1'b0;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 keypad matrix.
// Honours KEYPAD_REPEAT_EN to expect auto-repeat pulses.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;
`ifdef KEYPAD_REPEAT_EN
   localparam int REP_DELAY = 40;
   localparam int REP_RATE  = 16;
   localparam int HOLD1     = 30;
`else
   localparam int HOLD1     = 180;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row_i;
   logic [3:0]  col_o;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_pressed;
   logic [15:0] held = '0;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [3:0]  exp_q[$];
   int          pulse_cyc[$];
   logic        prev_valid = 1'b0;
   int          last_edge;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Keypad matrix: a held key at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_i = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (held[r*4+c] && (col_o[c] === 1'b0)) row_i[r] = 1'b0;
   end

   keypad_scanner #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB)
`ifdef KEYPAD_REPEAT_EN
      ,
      .REPEAT_DELAY    (REP_DELAY),
      .REPEAT_RATE     (REP_RATE)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .row_i       (row_i),
      .col_o       (col_o),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_pressed (key_pressed)
   );

   // Monitor: every pulse pops one expected code from the scoreboard.
   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         pulse_cyc.push_back(cyc);
         tests++;
         if (prev_valid) begin
            fails++;
            $display("[TB] FAIL pulse_width: key_valid high in consecutive cycles at cycle %0d, required one-cycle pulse", cyc);
         end else if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_pulse: key_valid with code %0h at cycle %0d, required no pulse", key_code, cyc);
         end else begin
            logic [3:0] exp;
            exp = exp_q.pop_front();
            if (key_code !== exp) begin
               fails++;
               $display("[TB] FAIL key_code: got %0h, expected %0h at cycle %0d", key_code, exp, cyc);
            end
         end
      end
      prev_valid = (key_valid === 1'b1);
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [15:0] keys);
      held = keys;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
      end
   endtask

   task automatic waitPressed(input string name);
      int n = 0;
      while (key_pressed !== 1'b1 && n < 300) begin
         tick(1);
         n++;
      end
      checkOutput(name, int'(key_pressed === 1'b1), 1);
   endtask

   task automatic waitColFresh(input logic [3:0] pattern, input string name);
      logic [3:0] prev;
      logic       found = 1'b0;
      int         n = 0;
      while (!found && n < 64) begin
         prev = col_o;
         tick(1);
         n++;
         if (col_o == pattern && prev != pattern) found = 1'b1;
      end
      checkOutput(name, int'(found), 1);
   endtask

   task automatic drainScoreboard(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         tick(1);
         n++;
      end
      tick(20);
      checkOutput(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      // Reset values
      applyStimulus(16'h0000);
      rst = 1'b1;
      tick(3);
      checkOutput("reset_col_o", col_o, 4'b1110);
      checkOutput("reset_key_valid", key_valid, 0);
      checkOutput("reset_key_code", key_code, 4'h0);
      checkOutput("reset_key_pressed", key_pressed, 0);
      rst = 1'b0;
      tick(2);

      // Clean press of '5' (row1/col1), long hold, release
      exp_q.push_back(4'h5);
      applyStimulus(16'h0001 << 5);
      waitPressed("press5_pressed");
      tick(HOLD1);
      applyStimulus(16'h0000);
      // two synchroniser stages plus eight debounce samples
      tick(9);
      checkOutput("press5_pressed_before_release_db", key_pressed, 1);
      tick(1);
      checkOutput("press5_released", key_pressed, 0);
      drainScoreboard("press5_drain");
      checkOutput("press5_code_held", key_code, 4'h5);

      // '*' (row3/col0) with three 3-cycle bounces, then stable
      pulse_cyc.delete();
      exp_q.push_back(4'hF);
      waitColFresh(4'b1110, "star_col0_reached");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(16'h0001 << 12);
         tick(3);
         applyStimulus(16'h0000);
         tick(3);
      end
      applyStimulus(16'h0001 << 12);
      last_edge = cyc;
      waitPressed("star_pressed");
      tick(1);
      checkOutput("star_pulse_seen", int'(pulse_cyc.size() >= 1), 1);
      if (pulse_cyc.size() >= 1) begin
         checkOutput("star_latency_min", int'(pulse_cyc[0] - last_edge >= 2 + DEB), 1);
         checkOutput("star_latency_max", int'(pulse_cyc[0] - last_edge <= 2 + DEB + SCAN_DIV - 1), 1);
      end
      tick(10);
      applyStimulus(16'h0000);
      drainScoreboard("star_drain");

      // Chord on col2 (rows 0 and 2): no pulse, scan keeps rotating
      applyStimulus((16'h0001 << 2) | (16'h0001 << 10));
      begin
         logic [3:0] prev;
         int         changes = 0;
         prev = col_o;
         for (int i = 0; i < 48; i++) begin
            tick(1);
            if (col_o != prev) begin
               checkOutput("chord_col_rotation", col_o, {prev[2:0], prev[3]});
               changes++;
               prev = col_o;
            end
         end
         checkOutput("chord_scan_continues", int'(changes >= 10), 1);
      end
      applyStimulus(16'h0000);
      drainScoreboard("chord_drain");

      // '9' held, then a second row on the same column joins mid-hold
      exp_q.push_back(4'h9);
      applyStimulus(16'h0001 << 10);
      waitPressed("nine_pressed");
      tick(10);
      applyStimulus((16'h0001 << 10) | (16'h0001 << 2));
      tick(15);
      checkOutput("nine_still_pressed", key_pressed, 1);
      applyStimulus(16'h0000);
      drainScoreboard("nine_drain");
      checkOutput("nine_code_held", key_code, 4'h9);

      // Reset mid-debounce of '0' (row3/col1), key kept held across reset
      waitColFresh(4'b1101, "zero_col1_reached");
      applyStimulus(16'h0001 << 13);
      // sampled at the 4th edge (deb_cnt=1), deb_cnt=5 after the 8th
      tick(8);
      rst = 1'b1;
      tick(2);
      checkOutput("zero_reset_pressed", key_pressed, 0);
      checkOutput("zero_reset_col_o", col_o, 4'b1110);
      exp_q.push_back(4'h0);
      rst = 1'b0;
      waitPressed("zero_after_reset_pressed");
      tick(5);
      applyStimulus(16'h0000);
      drainScoreboard("zero_drain");

      // '#' (row3/col2) held for 100 cycles after the first pulse
      pulse_cyc.delete();
`ifdef KEYPAD_REPEAT_EN
      repeat (5) exp_q.push_back(4'hE);
`else
      exp_q.push_back(4'hE);
`endif
      applyStimulus(16'h0001 << 14);
      waitPressed("hash_pressed");
      tick(100);
      applyStimulus(16'h0000);
      drainScoreboard("hash_drain");
`ifdef KEYPAD_REPEAT_EN
      checkOutput("hash_repeat_count", pulse_cyc.size(), 5);
      if (pulse_cyc.size() == 5) begin
         checkOutput("hash_first_repeat_gap", pulse_cyc[1] - pulse_cyc[0], REP_DELAY);
         for (int i = 2; i < 5; i++)
            checkOutput("hash_repeat_gap", pulse_cyc[i] - pulse_cyc[i-1], REP_RATE);
      end
`else
      checkOutput("hash_single_pulse", pulse_cyc.size(), 1);
`endif
      checkOutput("hash_code_held", key_code, 4'hE);
      checkOutput("hash_released", key_pressed, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 active-low matrix keypad and scans it column by column.
- Synchronises and debounces the row inputs.
- Emits one-cycle key_valid pulses with a 4-bit key_code. This is the producer side of the key_valid/key_code interface consumed by the setup and operational blocks of the lock.
- Exactly one key event per debounced press. Bounce, release and multi-key chords are filtered.

Parameters:
- SCAN_DIV, 1000: clk cycles each column stays driven before its rows are sampled (>=4).
- DEBOUNCE_CYCLES, 20000: consecutive identical samples required for press and for release.
- REPEAT_DELAY, 25000000: cycles held before the first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_RATE, 5000000: cycles between subsequent auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- row_i  in  4  keypad rows, active-low, externally pulled up, asynchronous
- col_o  out  4  keypad columns, one-hot active-low
- key_valid  out  1  one-cycle pulse, key_code valid
- key_code  out  4  code of the last accepted key, held between pulses
- key_pressed  out  1  level, high from the key_valid cycle until release is debounced

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=S_SCAN, col_idx=0, col_o=4'b1110, key_valid=0, key_code=4'h0, key_pressed=0, all counters 0, synchroniser flops 4'hF.
- Synchroniser: row_i passes through 2 flops (rows_s). Only rows_s is used internally.
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Key codes: digits map to their value; A..D map to 4'hA..4'hD; '#' maps to 4'hE; '*' maps to 4'hF (KC_STAR).
- S_SCAN:
  - div counter counts 0..SCAN_DIV-1 with col_o = ~(1<<col_idx).
  - At count SCAN_DIV-1, sample rows_s.
  - Exactly one row low: latch row_idx and col_idx, set deb_cnt=1, go to S_PRESS_DB. col_o is frozen.
  - No row low, or two or more rows low: col_idx <= col_idx+1 (wraps 3->0), div counter restarts.
- S_PRESS_DB:
  - Each cycle, if rows_s equals the latched one-hot pattern, deb_cnt increments. Otherwise go back to S_SCAN with the same col_idx and div counter at 0.
  - When deb_cnt==DEBOUNCE_CYCLES, go to S_EMIT.
- S_EMIT (1 cycle):
  - key_valid=1 and key_code=map(row_idx,col_idx), both registered, so the pulse is visible in this cycle.
  - key_pressed<=1, then go to S_HOLD.
  - Latency: first qualifying sample to key_valid high = DEBOUNCE_CYCLES cycles.
- S_HOLD: while the latched row stays low, stay. On rows_s==4'hF, set deb_cnt=1 and go to S_REL_DB. Any other pattern (second key pressed) is ignored and no event is emitted.
- S_REL_DB:
  - Requires DEBOUNCE_CYCLES consecutive samples of 4'hF.
  - Any low row returns to S_HOLD with deb_cnt cleared.
  - On completion: key_pressed<=0, col_idx<=col_idx+1, go to S_SCAN.
- key_valid is never high in two consecutive cycles, and never re-fires for the same press unless auto-repeat is compiled in.
- rst in any state, including mid-debounce: all state returns to reset values on the next edge. No pulse is emitted for a press interrupted by reset. A key still held after reset is re-detected and emits once after full debounce.
- Widths: all counters are sized with $clog2 of the largest parameter they compare against, +1. Comparisons are unsigned.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined: a rep_cnt runs in S_HOLD.
  - At REPEAT_DELAY cycles after S_EMIT, emit key_valid for 1 cycle with the same key_code.
  - After that, emit again every REPEAT_RATE cycles while held.
  - rep_cnt clears on leaving S_HOLD. Entering S_REL_DB pauses repeats; returning to S_HOLD restarts at REPEAT_RATE.
- Undefined: no repeat logic is present; exactly one pulse per press.

Decomposition:
- Shared package lock_pkg (existing) gains:
  - key code localparams KC_0..KC_9, KC_A..KC_D, KC_HASH=4'hE, KC_STAR=4'hF (the single source for consumers);
  - keypad_state_t enum.
- Sub-module keypad_sync: parameterised-width 2-flop synchroniser, reset value all-ones.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_RATE=16):
- Clean press on row1/col1 held 200 cycles, then release -> exactly one key_valid with key_code=4'h5. key_pressed rises with it and falls 8 cycles after rows go high.
- Press '*' (row3/col0) bouncing 3 on/off toggles of 3 cycles, then stable -> one pulse, key_code=4'hF, 8 cycles after the last bounce edge.
- Rows 0 and 2 low simultaneously on col2 -> no key_valid. Scanning continues: col_o cycles through 1110, 1101, 1011, 0111.
- Press '9' held, then a second row goes low mid-hold -> still a single pulse, key_code=4'h9. No pulse on the chord.
- rst asserted at deb_cnt=5 during a '0' press, '0' still held -> no pulse before reset. After reset, one pulse with key_code=4'h0 after full debounce.
- With KEYPAD_REPEAT_EN, hold '#' for 100 cycles -> pulses at EMIT, EMIT+40, EMIT+56, EMIT+72, EMIT+88, all with key_code=4'hE. Without the macro -> one pulse only.
